// File: rtl/mips_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_pkg
// Description : Shared constants and types for the MIPS load-use hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_hazard_pkg;

    localparam int NB_ADDR_DFLT = 5;
    localparam int MAX_LOAD_LAT = 4;
    localparam int ZERO_REG     = 0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } hz_state_e;

endpackage : mips_hazard_pkg
`default_nettype wire

// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard
// Description : Shift scoreboard of in-flight loads plus ID operand matching.
// Revision    : 1.0 - initial release
// ============================================================================
module load_scoreboard
    import mips_hazard_pkg::*;
#(
    parameter int NB_ADDR  = NB_ADDR_DFLT,
    parameter int LOAD_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_shift,
    input  logic                i_kill,
    input  logic                i_ld_valid,
    input  logic [NB_ADDR-1:0]  i_ld_addr,
    input  logic [NB_ADDR-1:0]  i_rs,
    input  logic [NB_ADDR-1:0]  i_rt,
    input  logic                i_uses_rs,
    input  logic                i_uses_rt,
    output logic [LOAD_LAT-1:0] o_valid,
    output logic                o_hit
);

    localparam logic [NB_ADDR-1:0] c_ZERO = NB_ADDR'(ZERO_REG);

    logic [LOAD_LAT-1:0] w_valid;
    logic [NB_ADDR-1:0]  w_addr [LOAD_LAT];
    logic [LOAD_LAT-1:0] w_match;

    // Entry 0 is the load currently in EX; it never occupies a register.
    assign w_valid[0] = i_ld_valid & (i_ld_addr != c_ZERO);
    assign w_addr[0]  = i_ld_addr;

    generate
        if (LOAD_LAT > 1) begin : g_regs
            logic [LOAD_LAT-1:1] r_valid;
            logic [NB_ADDR-1:0]  r_addr [1:LOAD_LAT-1];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_valid <= '0;
                    for (int k = 1; k < LOAD_LAT; k++) begin
                        r_addr[k] <= '0;
                    end
                end else if (i_shift) begin
                    // A squashed EX instruction must not enter the pipe as a load.
                    r_valid[1] <= w_valid[0] & ~i_kill;
                    r_addr[1]  <= w_addr[0];
                    for (int k = 2; k < LOAD_LAT; k++) begin
                        r_valid[k] <= r_valid[k-1];
                        r_addr[k]  <= r_addr[k-1];
                    end
                end
            end

            assign w_valid[LOAD_LAT-1:1] = r_valid;

            for (genvar k = 1; k < LOAD_LAT; k++) begin : g_addr
                assign w_addr[k] = r_addr[k];
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < LOAD_LAT; k++) begin : g_match
            assign w_match[k] = w_valid[k] & (w_addr[k] != c_ZERO) &
                                ((i_uses_rs & (i_rs == w_addr[k])) |
                                 (i_uses_rt & (i_rt == w_addr[k])));
        end
    endgenerate

    assign o_hit   = |w_match;
    assign o_valid = w_valid;

endmodule : load_scoreboard
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_unit
// Description : Load-use stall / branch flush control with sticky halt and
//               saturating debug counters for the 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit
    import mips_hazard_pkg::*;
#(
    parameter int NB_ADDR  = NB_ADDR_DFLT,
    parameter int LOAD_LAT = 1,
    parameter int NB_CNT   = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NB_ADDR-1:0]  i_rs_id,
    input  logic [NB_ADDR-1:0]  i_rt_id,
    input  logic                i_uses_rs,
    input  logic                i_uses_rt,
    input  logic                i_MemRead_ex,
    input  logic [NB_ADDR-1:0]  i_rt_ex,
    input  logic                i_branch_taken,
    input  logic                i_halt_ex,
    output logic                o_stall_flag,
    output logic                o_bubble,
    output logic                o_flush,
    output logic                o_halted,
    output logic [LOAD_LAT-1:0] o_pending,
    output logic [NB_CNT-1:0]   o_stall_count,
    output logic [NB_CNT-1:0]   o_flush_count
);

    localparam logic [NB_CNT-1:0] c_CNT_MAX = '1;

    hz_state_e           r_state;
    hz_state_e           w_state_next;
    logic                w_hit;
    logic                w_stall;
    logic                w_flush;
    logic [LOAD_LAT-1:0] w_pending;
    logic [NB_CNT-1:0]   r_stall_cnt;
    logic [NB_CNT-1:0]   r_flush_cnt;

    load_scoreboard #(
        .NB_ADDR  (NB_ADDR),
        .LOAD_LAT (LOAD_LAT)
    ) u_load_scoreboard (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_shift    (i_enable),
        .i_kill     (w_flush),
        .i_ld_valid (i_MemRead_ex),
        .i_ld_addr  (i_rt_ex),
        .i_rs       (i_rs_id),
        .i_rt       (i_rt_id),
        .i_uses_rs  (i_uses_rs),
        .i_uses_rt  (i_uses_rt),
        .o_valid    (w_pending),
        .o_hit      (w_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush wins over both stall and halt: the ID instruction and a HALT in
    // EX alongside a taken branch are both on the wrong path.
    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        w_stall      = 1'b0;
        if (!i_reset && i_enable) begin
            case (r_state)
                ST_RUN: begin
                    w_flush = i_branch_taken;
                    w_stall = w_hit & ~i_branch_taken;
                    if (i_halt_ex && !i_branch_taken) begin
                        w_state_next = ST_HALT;
                    end
                end
                default: begin
                    w_state_next = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + NB_CNT'(1);
            end
        end
    end

    assign o_stall_flag  = w_stall;
    assign o_bubble      = w_stall;
    assign o_flush       = w_flush;
    assign o_halted      = (r_state == ST_HALT);
    assign o_pending     = i_reset ? '0 : w_pending;
    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;

endmodule : hazard_scoreboard_unit
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard_unit
// Description : Self-checking bench driving a LOAD_LAT=1 and a LOAD_LAT=3
//               instance in parallel against an age-stamped load model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          reset, enable, uses_rs, uses_rt, memread_ex, br, halt_ex;
    logic [NB-1:0] rs_id, rt_id, rt_ex;

    logic       s1, b1, f1, h1;
    logic [0:0] p1;
    logic [2:0] sc1, fc1;
    logic       s3, b3, f3, h3;
    logic [2:0] p3;
    logic [7:0] sc3, fc3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.NB_ADDR(NB), .LOAD_LAT(1), .NB_CNT(3)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rs(uses_rs), .i_uses_rt(uses_rt),
        .i_MemRead_ex(memread_ex), .i_rt_ex(rt_ex), .i_branch_taken(br), .i_halt_ex(halt_ex),
        .o_stall_flag(s1), .o_bubble(b1), .o_flush(f1), .o_halted(h1),
        .o_pending(p1), .o_stall_count(sc1), .o_flush_count(fc1)
    );

    hazard_scoreboard_unit #(.NB_ADDR(NB), .LOAD_LAT(3), .NB_CNT(8)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rs(uses_rs), .i_uses_rt(uses_rt),
        .i_MemRead_ex(memread_ex), .i_rt_ex(rt_ex), .i_branch_taken(br), .i_halt_ex(halt_ex),
        .o_stall_flag(s3), .o_bubble(b3), .o_flush(f3), .o_halted(h3),
        .o_pending(p3), .o_stall_count(sc3), .o_flush_count(fc3)
    );

    // Reference model: committed loads carry the enabled-cycle stamp at which
    // they left EX; a load is pending while its age is below the latency.
    typedef struct {
        int            stamp;
        logic [NB-1:0] addr;
    } ld_t;

    ld_t lds[$];
    int  e_cnt    = 0;
    bit  m_halted = 1'b0;
    int  m_scnt1 = 0, m_fcnt1 = 0, m_scnt3 = 0, m_fcnt3 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_match(logic [NB-1:0] a);
        return (a != 0) && ((uses_rs && rs_id == a) || (uses_rt && rt_id == a));
    endfunction

    function automatic bit m_flush();
        return !reset && enable && br && !m_halted;
    endfunction

    function automatic bit m_stall(int lat);
        bit h = 1'b0;
        if (memread_ex && rt_ex != 0 && m_match(rt_ex)) h = 1'b1;
        foreach (lds[i]) begin
            if ((e_cnt - lds[i].stamp) < lat && m_match(lds[i].addr)) h = 1'b1;
        end
        return h && !reset && enable && !m_halted && !m_flush();
    endfunction

    function automatic logic [63:0] m_pend(int lat);
        logic [63:0] v = '0;
        if (!reset) begin
            v[0] = memread_ex && (rt_ex != 0);
            foreach (lds[i]) begin
                if ((e_cnt - lds[i].stamp) < lat) v[e_cnt - lds[i].stamp] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic int sat_inc(int c, int w);
        return (c == (1 << w) - 1) ? c : c + 1;
    endfunction

    task automatic compare_all();
        check("flush_l1",   f1,  m_flush());
        check("flush_l3",   f3,  m_flush());
        check("stall_l1",   s1,  m_stall(1));
        check("stall_l3",   s3,  m_stall(3));
        check("bubble_l1",  b1,  m_stall(1));
        check("bubble_l3",  b3,  m_stall(3));
        check("pending_l1", p1,  m_pend(1));
        check("pending_l3", p3,  m_pend(3));
        check("halted_l1",  h1,  m_halted);
        check("halted_l3",  h3,  m_halted);
        check("scnt_l1",    sc1, m_scnt1);
        check("fcnt_l1",    fc1, m_fcnt1);
        check("scnt_l3",    sc3, m_scnt3);
        check("fcnt_l3",    fc3, m_fcnt3);
    endtask

    task automatic apply(input int rst, input int en, input int mr, input int rtx,
                         input int rs, input int urs, input int rt, input int urt,
                         input int b, input int h);
        reset      = (rst != 0);
        enable     = (en != 0);
        memread_ex = (mr != 0);
        rt_ex      = NB'(rtx);
        rs_id      = NB'(rs);
        uses_rs    = (urs != 0);
        rt_id      = NB'(rt);
        uses_rt    = (urt != 0);
        br         = (b != 0);
        halt_ex    = (h != 0);
        #3;
        compare_all();
    endtask

    task automatic tick();
        bit fl, st1, st3;
        @(posedge clk);
        fl  = m_flush();
        st1 = m_stall(1);
        st3 = m_stall(3);
        if (reset) begin
            lds.delete();
            m_halted = 1'b0;
            m_scnt1 = 0; m_fcnt1 = 0; m_scnt3 = 0; m_fcnt3 = 0;
        end else if (enable) begin
            if (st1) m_scnt1 = sat_inc(m_scnt1, 3);
            if (st3) m_scnt3 = sat_inc(m_scnt3, 8);
            if (fl) begin
                m_fcnt1 = sat_inc(m_fcnt1, 3);
                m_fcnt3 = sat_inc(m_fcnt3, 8);
            end
            if (!m_halted && halt_ex && !fl) m_halted = 1'b1;
            if (memread_ex && rt_ex != 0 && !fl) lds.push_back('{e_cnt, rt_ex});
            e_cnt++;
            while (lds.size() > 0 && (e_cnt - lds[0].stamp) >= 4) void'(lds.pop_front());
        end
        #1;
    endtask

    task automatic step(input int rst, input int en, input int mr, input int rtx,
                        input int rs, input int urs, input int rt, input int urt,
                        input int b, input int h);
        apply(rst, en, mr, rtx, rs, urs, rt, urt, b, h);
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; memread_ex = 1'b0; rt_ex = '0;
        rs_id = '0; rt_id = '0; uses_rs = 1'b0; uses_rt = 1'b0; br = 1'b0; halt_ex = 1'b0;
        tick();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_halted", h3, 0);
        check("rst_scnt",   sc3, 0);

        // Classic single-bubble load-use
        apply(0, 1, 1, 3, 3, 1, 0, 0, 0, 0);
        check("A_stall_l1", s1, 1);
        check("A_bubble_l1", b1, 1);
        tick();
        apply(0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        check("A_stall_l1_next", s1, 0);
        tick();
        check("A_scnt_l1", sc1, 1);

        // Three-cycle latency, immediate consumer
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 5, 5, 1, 0, 0, 0, 0);
        check("B_pend0", p3, 3'b001); check("B_stall0", s3, 1);
        tick();
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        check("B_pend1", p3, 3'b010); check("B_stall1", s3, 1);
        tick();
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        check("B_pend2", p3, 3'b100); check("B_stall2", s3, 1);
        tick();
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        check("B_stall3", s3, 0); check("B_pend3", p3, 3'b000);
        tick();
        check("B_scnt", sc3, 3);

        // Consumer two instructions behind the load
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 5, 1, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0); check("B2_stall0", s3, 1); tick();
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0); check("B2_stall1", s3, 1); tick();
        apply(0, 1, 0, 0, 5, 1, 0, 0, 0, 0); check("B2_stall2", s3, 0); tick();
        check("B2_scnt", sc3, 2);

        // Register zero and unused rt never stall
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        check("C_zero_l1", s1, 0); check("C_zero_l3", s3, 0);
        tick();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 6, 1, 1, 6, 0, 0, 0);
        check("C_rt_unused_l1", s1, 0); check("C_rt_unused_l3", s3, 0);
        tick();
        repeat (3) step(0, 1, 0, 0, 6, 0, 6, 0, 0, 0);

        // Branch beats load-use; branch beats HALT
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 4, 4, 1, 0, 0, 1, 0);
        check("D_flush", f3, 1); check("D_stall", s3, 0);
        tick();
        apply(0, 1, 0, 0, 4, 1, 0, 0, 0, 0);
        check("D_pend_killed", p3, 3'b000); check("D_stall_next", s3, 0);
        tick();
        check("D_fcnt_l1", fc1, 1); check("D_fcnt_l3", fc3, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        check("D_halt_squashed", h3, 0);

        // Sticky halt
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("E_halted", h1, 1);
        apply(0, 1, 1, 2, 2, 1, 0, 0, 0, 0);
        check("E_stall_l1", s1, 0); check("E_stall_l3", s3, 0);
        tick();
        step(0, 1, 0, 0, 2, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("E_still_halted", h3, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("E_rst_halted", h1, 0); check("E_rst_fcnt", fc3, 0);

        // Freeze mid-stall
        apply(0, 1, 1, 6, 6, 1, 0, 0, 0, 0); check("F_stall0", s3, 1); tick();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
            check("F_frozen_pend", p3, 3'b010);
            check("F_frozen_stall", s3, 0);
            tick();
        end
        check("F_frozen_scnt", sc3, 1);
        apply(0, 1, 0, 0, 6, 1, 0, 0, 0, 0); check("F_resume1", s3, 1); tick();
        apply(0, 1, 0, 0, 6, 1, 0, 0, 0, 0); check("F_resume2", s3, 1); tick();
        apply(0, 1, 0, 0, 6, 1, 0, 0, 0, 0); check("F_resume3", s3, 0); tick();
        check("F_scnt", sc3, 3);

        // Reset in the middle of a stall
        step(0, 1, 1, 7, 7, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        check("G_pend", p3, 3'b000); check("G_stall", s3, 0);
        tick();

        // Randomized traffic on a small register set to provoke hits
        for (int i = 0; i < 800; i++) begin
            step(int'($urandom_range(0, 59) == 0), int'($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 11) == 0), int'($urandom_range(0, 79) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard_unit
`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised load-use hazard unit for the 5-stage MIPS pipeline, sitting alongside the forwarding unit and sampling the ID, EX and branch-resolution signals.
- Tracks in-flight loads across a configurable number of post-EX latency stages in a shift scoreboard, so multi-cycle data memories are supported.
- Generates stall, bubble and flush controls, latches a sticky halt, and keeps saturating stall/flush counters for the debug unit.

Parameters:
- NB_ADDR, 5, register address width.
- LOAD_LAT, 1, cycles after EX until load data is forwardable. Range 1..4; 1 means classic one-bubble MIPS.
- NB_CNT, 32, width of the debug counters.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  pipeline advance enable (debug step); 0 freezes all state.
- i_rs_id  in  NB_ADDR  rs of the instruction in ID.
- i_rt_id  in  NB_ADDR  rt of the instruction in ID.
- i_uses_rs  in  1  ID instruction reads rs.
- i_uses_rt  in  1  ID instruction reads rt.
- i_MemRead_ex  in  1  instruction in EX is a load.
- i_rt_ex  in  NB_ADDR  load destination in EX.
- i_branch_taken  in  1  branch/jump resolved taken in EX.
- i_halt_ex  in  1  HALT opcode in EX.
- o_stall_flag  out  1  hold PC and IF/ID.
- o_bubble  out  1  zero ID/EX control next edge.
- o_flush  out  1  flush IF/ID and ID/EX.
- o_halted  out  1  sticky halt state.
- o_pending  out  LOAD_LAT  valid bits of the scoreboard (debug).
- o_stall_count  out  NB_CNT  stall cycles.
- o_flush_count  out  NB_CNT  flush cycles.

Behaviour:
- Clock i_clk; reset i_reset is synchronous, active-high.
- Reset values: scoreboard all invalid, o_pending=0, o_halted=0, both counters=0. Combinational outputs are forced to 0 while i_reset=1.
- Scoreboard: entries 0..LOAD_LAT-1, each holding {valid, addr}.
  - Entry 0 represents the EX stage and is driven combinationally from i_MemRead_ex & (i_rt_ex!=0) and i_rt_ex.
  - Entries 1..LOAD_LAT-1 are registered.
  - On each edge with i_enable=1 and no reset: entry k+1 <= entry k. The oldest entry is dropped.
  - If o_flush=1, entry 1 loads invalid, because the squashed EX instruction never commits.
- Match: hit = OR over valid entries of ((i_uses_rs & i_rs_id==addr) | (i_uses_rt & i_rt_id==addr)). Register 0 never matches.
- o_stall_flag = hit & ~o_flush & ~o_halted & i_enable. o_bubble = o_stall_flag.
  - LOAD_LAT=1 yields exactly one bubble per load-use pair.
  - LOAD_LAT=N yields up to N bubbles, shrinking with distance between the load and its consumer.
- o_flush = i_branch_taken & ~o_halted & i_enable. Flush has priority over stall, since the ID instruction is on the wrong path.
- FSM, two states:
  - RUN -> HALT when i_halt_ex & i_enable & ~o_flush.
  - HALT is sticky until reset.
  - In HALT: o_stall_flag=0, o_flush=0, the scoreboard keeps shifting so in-flight loads drain, counters frozen.
- Counters increment on enabled edges in RUN when their flag is 1, and saturate at all-ones with no wrap.
- i_enable=0: no state changes; stall and flush outputs read 0.
- Simultaneous HALT and taken branch in the same cycle: the branch wins and the HALT is squashed.
- Reset asserted mid-stall: next cycle all pending entries are invalid and there is no stall.

Decomposition:
- Shared package mips_hazard_pkg:
  - NB_ADDR default.
  - ZERO_REG constant.
  - State encodings ST_RUN/ST_HALT.
  - Maximum LOAD_LAT constant (4).
- One natural sub-module, load_scoreboard: the shift register plus match logic, parametrised by NB_ADDR and LOAD_LAT. FSM and counters stay in the top level.

Test Plan:
- LOAD_LAT=1, lw $3 in EX, ID add uses rs=3 -> stall=1 and bubble=1 for one cycle, then 0; stall_count=1.
- LOAD_LAT=3, lw $5 then immediate consumer of $5 -> stall held 3 cycles, o_pending walks 001->010->100, stall_count=3. Consumer two instructions later -> 2 stalls.
- lw $0 followed by a reader of $0 -> no stall. Reader with i_uses_rt=0 and rt matching -> no stall.
- Load-use stall and i_branch_taken in the same cycle -> flush=1, stall=0, entry 1 invalid next cycle, flush_count=1.
- i_halt_ex=1 -> o_halted=1 next edge and sticky. A later load-use pair gives stall=0 and counters unchanged. i_reset=1 -> o_halted=0 and counters 0.
- i_enable=0 for 5 cycles mid-stall -> o_pending and counters frozen. Re-enable resumes the remaining stall cycles exactly.
